// File: rtl/rca_pkg.sv
// Shared constants and elaboration helpers for the carry-pipelined ripple adder.
// Segment width and configuration legality live here so every file agrees on them.
package rca_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int seg_width(input int width, input int stages);
        return (stages >= 1) ? width / stages : width;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// Operand/result bundle for pipelined_rca; the producer side is master, the adder is slave.
interface pipelined_rca_if #(parameter int WIDTH = 16);

    logic             enable;
    logic             in_valid;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic [WIDTH:0]   Q;
    logic             ovf;

    modport master (
        output enable, in_valid, sub, A, B, Cin,
        input  out_valid, Q, ovf
    );

    modport slave (
        input  enable, in_valid, sub, A, B, Cin,
        output out_valid, Q, ovf
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple segments.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_segment.sv
// Purely combinational SEG-bit ripple chain; also exposes the carry into its MSB
// so the final segment can derive signed overflow as carry-in(MSB) ^ carry-out.
module rca_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        logic c_in;
        logic c_out;
        if (i == 0) begin : g_lsb
            assign c_in = ci;
        end else begin : g_upper
            assign c_in = g_bit[i-1].c_out;
        end
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_in),
            .s  (s[i]),
            .co (c_out)
        );
    end

    assign co    = g_bit[SEG-1].c_out;
    assign c_msb = g_bit[SEG-1].c_in;

endmodule

// File: rtl/pipelined_rca.sv
// Carry-pipelined ripple adder/subtractor: STAGES segments separated by registers that
// carry the partial sum, the skewed operands, the segment carry and a valid tag.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic             clk,
    input logic             rst_n,
    pipelined_rca_if.slave  bus
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_rca: STAGES must be >= 1 and divide WIDTH");
    end

    typedef logic [WIDTH-1:0] word_t;

    word_t a_q   [STAGES];
    word_t a_d   [STAGES];
    word_t be_q  [STAGES];
    word_t be_d  [STAGES];
    word_t sum_q [STAGES];
    word_t sum_d [STAGES];
    logic  carry_q [STAGES];
    logic  carry_d [STAGES];
    logic  valid_q [STAGES];
    logic  valid_d [STAGES];
    logic  ovf_stage [STAGES];
    logic  ovf_q;
    logic  ovf_d;

    // Operands are passed whole between stages; bits already consumed are dead and get pruned.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam word_t SEG_MASK = word_t'({SEG{1'b1}}) << (k * SEG);

        word_t          a_src;
        word_t          be_src;
        word_t          sum_src;
        logic           c_src;
        logic           v_src;
        logic [SEG-1:0] seg_sum;
        logic           seg_co;
        logic           seg_cmsb;

        if (k == 0) begin : g_first
            assign a_src   = bus.A;
            assign be_src  = bus.B ^ {WIDTH{bus.sub}};
            assign sum_src = '0;
            assign c_src   = bus.Cin ^ bus.sub;
            assign v_src   = bus.in_valid;
        end else begin : g_next
            assign a_src   = a_q[k-1];
            assign be_src  = be_q[k-1];
            assign sum_src = sum_q[k-1];
            assign c_src   = carry_q[k-1];
            assign v_src   = valid_q[k-1];
        end

        rca_segment #(.SEG(SEG)) u_seg (
            .a     (a_src[k*SEG +: SEG]),
            .b     (be_src[k*SEG +: SEG]),
            .ci    (c_src),
            .s     (seg_sum),
            .co    (seg_co),
            .c_msb (seg_cmsb)
        );

        assign a_d[k]       = a_src;
        assign be_d[k]      = be_src;
        assign sum_d[k]     = (sum_src & ~SEG_MASK) | (word_t'(seg_sum) << (k * SEG));
        assign carry_d[k]   = seg_co;
        assign valid_d[k]   = v_src;
        assign ovf_stage[k] = seg_cmsb ^ seg_co;
    end

    assign ovf_d = ovf_stage[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                be_q[k]    <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (bus.enable) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                be_q[k]    <= be_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.Q         = {carry_q[STAGES-1], sum_q[STAGES-1]};
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: directed scenarios on a 16/4 instance plus
// randomized runs against an arithmetic delay-line model on several geometries.
module tb_pipelined_rca;
    import rca_pkg::*;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   cfg_start = 1'b0;

    always #5 clk = ~clk;

    pipelined_rca_if #(.WIDTH(WIDTH)) bus ();

    pipelined_rca #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          v;
        logic [64:0] q;
        bit          o;
    } exp_t;

    typedef struct {
        bit          en;
        bit          iv;
        bit          sb;
        logic [15:0] a;
        logic [15:0] b;
        bit          ci;
        bit          vexp;
        logic [16:0] qexp;
        bit          oexp;
    } step_t;

    // Plain integer arithmetic: unsigned sum for Q, signed range test for overflow.
    function automatic exp_t ref_op(int w, bit valid, logic [63:0] a, logic [63:0] b, bit sb, bit cin);
        exp_t   r;
        longint full, ua, ube, ci, sa, sbe, sr;
        full = longint'(1) << w;
        ua   = longint'(a) & (full - 1);
        ube  = longint'(sb ? ~b : b) & (full - 1);
        ci   = (cin ^ sb) ? 1 : 0;
        sa   = (ua  >= full / 2) ? ua  - full : ua;
        sbe  = (ube >= full / 2) ? ube - full : ube;
        sr   = sa + sbe + ci;
        r.v  = valid;
        r.q  = 65'(ua + ube + ci);
        r.o  = (sr >= full / 2) || (sr < -(full / 2));
        return r;
    endfunction

    exp_t pipe[$];

    function automatic void model_reset();
        exp_t z;
        z.v = 1'b0; z.q = '0; z.o = 1'b0;
        pipe.delete();
        for (int i = 0; i < STAGES; i++) pipe.push_back(z);
    endfunction

    task automatic drive(bit en, bit iv, bit sb, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, bit ci);
        bus.enable = en; bus.in_valid = iv; bus.sub = sb;
        bus.A = a; bus.B = b; bus.Cin = ci;
        @(posedge clk);
        if (en) begin
            pipe.push_front(ref_op(WIDTH, iv, 64'(a), 64'(b), sb, ci));
            void'(pipe.pop_back());
        end
        @(negedge clk);
    endtask

    // Extra geometries run concurrently with their own models once cfg_start rises.
    localparam int CW [3] = '{4, 8, 32};
    localparam int CS [3] = '{4, 1, 8};

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W = CW[g];
        localparam int S = CS[g];
        bit done_flag = 1'b0;

        pipelined_rca_if #(.WIDTH(W)) cbus ();

        pipelined_rca #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (cbus)
        );

        initial begin
            exp_t        cp[$];
            exp_t        e;
            bit          en, iv, sb, ci;
            logic [63:0] a, b;
            cbus.enable = 1'b0; cbus.in_valid = 1'b0; cbus.sub = 1'b0;
            cbus.A = '0; cbus.B = '0; cbus.Cin = 1'b0;
            e.v = 1'b0; e.q = '0; e.o = 1'b0;
            for (int i = 0; i < S; i++) cp.push_back(e);
            wait (cfg_start);
            @(negedge clk);
            for (int n = 0; n < 10000; n++) begin
                en = ($urandom_range(0, 9) < 8);
                iv = ($urandom_range(0, 9) < 7);
                sb = $urandom_range(0, 1) == 1;
                ci = $urandom_range(0, 1) == 1;
                a  = {$urandom, $urandom};
                b  = {$urandom, $urandom};
                cbus.enable = en; cbus.in_valid = iv; cbus.sub = sb; cbus.Cin = ci;
                cbus.A = a[W-1:0]; cbus.B = b[W-1:0];
                @(posedge clk);
                if (en) begin
                    cp.push_front(ref_op(W, iv, a, b, sb, ci));
                    void'(cp.pop_back());
                end
                @(negedge clk);
                e = cp[$];
                n_checks++;
                if (cbus.out_valid !== e.v) begin
                    n_fail++;
                    $display("FAIL cfg%0d_out_valid cycle %0d: got %b expected %b", g, n, cbus.out_valid, e.v);
                end
                if (e.v) begin
                    n_checks++;
                    if (cbus.Q !== e.q[W:0]) begin
                        n_fail++;
                        $display("FAIL cfg%0d_q cycle %0d: got %h expected %h", g, n, cbus.Q, e.q[W:0]);
                    end
                    n_checks++;
                    if (cbus.ovf !== e.o) begin
                        n_fail++;
                        $display("FAIL cfg%0d_ovf cycle %0d: got %b expected %b", g, n, cbus.ovf, e.o);
                    end
                end
            end
            done_flag = 1'b1;
        end
    end

    task automatic test_reset();
        bus.enable = 1'b1; bus.in_valid = 1'b1; bus.sub = 1'b0;
        bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.Cin = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.Q !== 17'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 00000", bus.Q); end
        n_checks++;
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_add();
        step_t st [5] = '{
            '{1, 1, ADD, 16'hFFFF, 16'h0001, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h10000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0}
        };
        for (int i = 0; i < 5; i++) begin
            drive(st[i].en, st[i].iv, st[i].sb, st[i].a, st[i].b, st[i].ci);
            n_checks++;
            if (bus.out_valid !== st[i].vexp) begin n_fail++; $display("FAIL single_add_valid step %0d: got %b expected %b", i, bus.out_valid, st[i].vexp); end
            if (st[i].vexp) begin
                n_checks++;
                if (bus.Q !== st[i].qexp) begin n_fail++; $display("FAIL single_add_q step %0d: got %h expected %h", i, bus.Q, st[i].qexp); end
                n_checks++;
                if (bus.ovf !== st[i].oexp) begin n_fail++; $display("FAIL single_add_ovf step %0d: got %b expected %b", i, bus.ovf, st[i].oexp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st [10] = '{
            '{1, 1, ADD, 16'h7FFF, 16'h0001, 0, 0, 17'h00000, 0},
            '{1, 1, SUB, 16'h1234, 16'h1234, 0, 0, 17'h00000, 0},
            '{1, 1, SUB, 16'h0000, 16'h0001, 0, 0, 17'h00000, 0},
            '{1, 1, SUB, 16'h8000, 16'h0001, 1, 1, 17'h08000, 1},
            '{1, 1, ADD, 16'h0005, 16'h0003, 1, 1, 17'h10000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h0FFFF, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h17FFE, 1},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h00009, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0}
        };
        for (int i = 0; i < 10; i++) begin
            drive(st[i].en, st[i].iv, st[i].sb, st[i].a, st[i].b, st[i].ci);
            n_checks++;
            if (bus.out_valid !== st[i].vexp) begin n_fail++; $display("FAIL b2b_valid step %0d: got %b expected %b", i, bus.out_valid, st[i].vexp); end
            if (st[i].vexp) begin
                n_checks++;
                if (bus.Q !== st[i].qexp) begin n_fail++; $display("FAIL b2b_q step %0d: got %h expected %h", i, bus.Q, st[i].qexp); end
                n_checks++;
                if (bus.ovf !== st[i].oexp) begin n_fail++; $display("FAIL b2b_ovf step %0d: got %b expected %b", i, bus.ovf, st[i].oexp); end
            end
        end
    endtask

    task automatic test_stall_bubble();
        step_t st [17] = '{
            '{1, 1, ADD, 16'h00FF, 16'h0F01, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{0, 1, ADD, 16'hFFFF, 16'hFFFF, 1, 0, 17'h00000, 0},
            '{0, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{0, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h01000, 0},
            '{0, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h01000, 0},
            '{0, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h01000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 1, ADD, 16'h0001, 16'h0001, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 1, ADD, 16'h0003, 16'h0004, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h00002, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 1, 17'h00007, 0},
            '{1, 0, ADD, 16'h0000, 16'h0000, 0, 0, 17'h00000, 0}
        };
        for (int i = 0; i < 17; i++) begin
            drive(st[i].en, st[i].iv, st[i].sb, st[i].a, st[i].b, st[i].ci);
            n_checks++;
            if (bus.out_valid !== st[i].vexp) begin n_fail++; $display("FAIL stall_valid step %0d: got %b expected %b", i, bus.out_valid, st[i].vexp); end
            if (st[i].vexp) begin
                n_checks++;
                if (bus.Q !== st[i].qexp) begin n_fail++; $display("FAIL stall_q step %0d: got %h expected %h", i, bus.Q, st[i].qexp); end
                n_checks++;
                if (bus.ovf !== st[i].oexp) begin n_fail++; $display("FAIL stall_ovf step %0d: got %b expected %b", i, bus.ovf, st[i].oexp); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        drive(1, 1, ADD, 16'h7FFF, 16'h0001, 0);
        drive(1, 1, ADD, 16'h0001, 16'h0001, 0);
        drive(1, 1, ADD, 16'h0002, 16'h0002, 0);
        drive(1, 1, ADD, 16'h0003, 16'h0003, 0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.Q !== 17'h08000 || bus.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_pre: got v=%b q=%h ovf=%b expected v=1 q=08000 ovf=1", bus.out_valid, bus.Q, bus.ovf);
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.Q !== 17'h0) begin n_fail++; $display("FAIL midflight_q: got %h expected 00000", bus.Q); end
        n_checks++;
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL midflight_ovf: got %b expected 0", bus.ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < STAGES + 2; i++) begin
            drive(1, 0, ADD, 16'h0, 16'h0, 0);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midflight_stale step %0d: got %b expected 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int n = 0; n < 10000; n++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 1) == 1);
            e = pipe[$];
            n_checks++;
            if (bus.out_valid !== e.v) begin n_fail++; $display("FAIL random_valid cycle %0d: got %b expected %b", n, bus.out_valid, e.v); end
            if (e.v) begin
                n_checks++;
                if (bus.Q !== e.q[WIDTH:0]) begin n_fail++; $display("FAIL random_q cycle %0d: got %h expected %h", n, bus.Q, e.q[WIDTH:0]); end
                n_checks++;
                if (bus.ovf !== e.o) begin n_fail++; $display("FAIL random_ovf cycle %0d: got %b expected %b", n, bus.ovf, e.o); end
            end
        end
    endtask

    task automatic test_random_configs();
        int  budget;
        bit  all_done;
        bus.enable = 1'b0; bus.in_valid = 1'b0;
        cfg_start = 1'b1;
        budget = 0;
        all_done = 1'b0;
        while (!all_done && budget < 40000) begin
            @(negedge clk);
            budget++;
            all_done = g_cfg[0].done_flag && g_cfg[1].done_flag && g_cfg[2].done_flag;
        end
        n_checks++;
        if (!all_done) begin
            n_fail++;
            $display("FAIL random_configs_timeout: got done=%b%b%b expected 111", g_cfg[2].done_flag, g_cfg[1].done_flag, g_cfg[0].done_flag);
        end
    endtask

    initial begin
        bus.enable = 1'b0; bus.in_valid = 1'b0; bus.sub = 1'b0;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_add();
        test_back_to_back();
        test_stall_bubble();
        test_reset_midflight();
        test_random();
        test_random_configs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
